// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// Issues sequential word-aligned fetches to a variable-latency instruction
// memory, buffers the in-order responses in a prefetch FIFO and presents
// {pc, instruction} pairs to decode. A redirect flushes the FIFO, marks every
// outstanding request as stale and restarts fetch at the new address.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = AW + 1;
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [31:0]   redirect_target;
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_seen;
  logic          push;
  logic          pop;

  // Low address bits of a redirect target are ignored.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Every accepted request owns a FIFO slot until it is answered or popped,
  // so a response can always be written without back-pressure.
  assign occupancy = {1'b0, inflight} + {1'b0, count};
  assign credit_ok = (occupancy < DEPTH_W);

  // Gated with rst_n so the request channel is quiet while reset is held.
  assign mem_req_valid = rst_n & credit_ok & ~redirect_valid;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid & mem_req_ready;

  // A response with nothing outstanding is ignored to keep counters sane.
  assign rsp_seen = mem_rsp_valid & (inflight != '0);

  // Responses for stale requests, or arriving in a redirect cycle, are dropped.
  assign push = rsp_seen & (drop_cnt == '0) & ~redirect_valid;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // Fetch address generator: advance on acceptance, reload on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC tag for the next kept response; tracks fetch_pc in response order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pc <= START_PC;
    end else if (redirect_valid) begin
      rsp_pc <= redirect_target;
    end else if (push) begin
      rsp_pc <= rsp_pc + 32'd4;
    end
  end

  // Outstanding request counter, including requests that will be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({req_fire, rsp_seen})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Stale-response counter: a redirect marks everything still outstanding
  // (minus a response consumed in the same cycle) as stale, replacing any
  // previous count since those requests are part of the outstanding set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= rsp_seen ? (inflight - CW'(1)) : inflight;
    end else if (rsp_seen && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue by snapping the
  // read pointer onto the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: registered entries, no bypass from response to output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a behavioural
// in-order instruction memory of programmable latency.
module tb_fetch_queue;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_out_valid;
  logic [31:0] w_out_instr, w_out_pc;
  logic        w_req_ready = 1'b1;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_out_ready = 1'b1;

  int          checks   = 0;
  int          failures = 0;
  int unsigned lat      = 1;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc)
  );

  // Memory for the main DUT: a request accepted at edge c is sampled by the
  // DUT as a response at edge c+lat, in order, reset together with the DUT.
  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } req_t;
  req_t        q[$];
  int unsigned cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc           <= 0;
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (mem_req_valid && mem_req_ready) begin
        q.push_back('{due: cyc + 1 + lat, addr: mem_req_addr});
      end
      if (q.size() > 0 && q[0].due <= cyc + 2) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= q[0].addr ^ PAT;
        void'(q.pop_front());
      end else begin
        mem_rsp_valid <= 1'b0;
      end
    end
  end

  // Memory for the wrap-around instance: always ready, fixed 1-cycle latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= '0;
    end else begin
      w_rsp_valid <= w_req_valid;
      w_rsp_data  <= w_req_addr ^ PAT;
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input logic ordy, input int unsigned l);
    step();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    mem_req_ready  = 1'b0;
    repeat (2) step();
    lat           = l;
    mem_req_ready = rdy;
    out_ready     = ordy;
    rst_n         = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (w_req_valid !== 1'b0) begin failures++; $display("FAIL reset_w_req_valid got=%b exp=0", w_req_valid); end
  endtask

  task automatic test_sequential;
    do_reset(1'b1, 1'b1, 1);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      failures++; $display("FAIL seq_first_req got=%b/%h exp=1/00000000", mem_req_valid, mem_req_addr); end
    step();
    checks++; if (out_valid !== 1'b0 || mem_req_addr !== 32'h4) begin
      failures++; $display("FAIL seq_cycle1 got=%b/%h exp=0/00000004", out_valid, mem_req_addr); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== PAT) begin
      failures++; $display("FAIL seq_first_out got=%b/%h/%h exp=1/00000000/%h", out_valid, out_pc, out_instr, PAT); end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== (32'(i * 4) ^ PAT)) begin
        failures++; $display("FAIL seq_stream[%0d] got=%b/%h/%h exp=1/%h", i, out_valid, out_pc, out_instr, 32'(i * 4)); end
    end
  endtask

  task automatic test_backpressure;
    int          acc = 0;
    logic [31:0] first_a = '1, last_a = '1;
    do_reset(1'b1, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      if (mem_req_valid && mem_req_ready) begin
        if (acc == 0) first_a = mem_req_addr;
        last_a = mem_req_addr;
        acc++;
      end
      step();
    end
    checks++; if (acc !== 4) begin failures++; $display("FAIL bp_accept_count got=%0d exp=4", acc); end
    checks++; if (first_a !== 32'h0 || last_a !== 32'hC) begin
      failures++; $display("FAIL bp_addrs got=%h..%h exp=00000000..0000000c", first_a, last_a); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got=%b exp=0", mem_req_valid); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL bp_head got=%b/%h exp=1/00000000", out_valid, out_pc); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL bp_after_pop got=%h exp=00000004", out_pc); end
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req_valid && mem_req_ready) begin
        last_a = mem_req_addr;
        acc++;
      end
      step();
    end
    checks++; if (acc !== 1 || last_a !== 32'h10) begin
      failures++; $display("FAIL bp_one_more got=%0d/%h exp=1/00000010", acc, last_a); end
  endtask

  task automatic test_redirect_drain;
    int          seen = 0, stale = 0;
    logic [31:0] p0 = '1, i0 = '1, p1 = '1;
    do_reset(1'b1, 1'b1, 3);
    repeat (3) step();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hC) begin
      failures++; $display("FAIL rd_pre got=%b/%h exp=1/0000000c", mem_req_valid, mem_req_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rd_no_req_in_redirect got=%b exp=0", mem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
      failures++; $display("FAIL rd_restart got=%b/%h exp=1/00000100", mem_req_valid, mem_req_addr); end
    for (int i = 0; i < 20 && seen < 2; i++) begin
      if (out_valid) begin
        if (out_pc < 32'h100) stale++;
        if (seen == 0) begin p0 = out_pc; i0 = out_instr; end
        else p1 = out_pc;
        seen++;
      end
      step();
    end
    checks++; if (seen !== 2) begin failures++; $display("FAIL rd_timeout got=%0d exp=2", seen); end
    checks++; if (p0 !== 32'h100 || i0 !== (32'h100 ^ PAT) || p1 !== 32'h104) begin
      failures++; $display("FAIL rd_first_out got=%h/%h,%h exp=00000100/%h,00000104", p0, i0, p1, 32'h100 ^ PAT); end
    checks++; if (stale !== 0) begin failures++; $display("FAIL rd_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_redirect_pop;
    int          seen = 0, bad = 0;
    logic [31:0] exp_pc = 32'h200, i0 = '1;
    do_reset(1'b1, 1'b1, 2);
    repeat (8) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_instr !== (32'h14 ^ PAT) || mem_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL rp_pre got=%b/%h/%h rsp=%b exp=1/00000014 rsp=1", out_valid, out_pc, out_instr, mem_rsp_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) begin
        if (out_pc !== exp_pc || out_instr !== (exp_pc ^ PAT)) bad++;
        if (seen == 0) i0 = out_instr;
        exp_pc += 32'h4;
        seen++;
      end
      step();
    end
    checks++; if (seen < 2) begin failures++; $display("FAIL rp_timeout got=%0d exp>=2", seen); end
    checks++; if (i0 !== (32'h200 ^ PAT)) begin failures++; $display("FAIL rp_first_instr got=%h exp=%h", i0, 32'h200 ^ PAT); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rp_sequence got=%0d bad exp=0", bad); end
  endtask

  task automatic test_wrap;
    do_reset(1'b1, 1'b1, 1);
    checks++; if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFF8) begin
      failures++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffff8", w_req_valid, w_req_addr); end
    step();
    checks++; if (w_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req1 got=%h exp=fffffffc", w_req_addr); end
    step();
    checks++; if (w_req_addr !== 32'h0 || w_out_valid !== 1'b1 || w_out_pc !== 32'hFFFF_FFF8 || w_out_instr !== (32'hFFFF_FFF8 ^ PAT)) begin
      failures++; $display("FAIL wrap_out0 got=%h/%b/%h/%h exp=00000000/1/fffffff8", w_req_addr, w_out_valid, w_out_pc, w_out_instr); end
    step();
    checks++; if (w_out_valid !== 1'b1 || w_out_pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_out1 got=%b/%h exp=1/fffffffc", w_out_valid, w_out_pc); end
    step();
    checks++; if (w_out_valid !== 1'b1 || w_out_pc !== 32'h0 || w_out_instr !== PAT) begin
      failures++; $display("FAIL wrap_out2 got=%b/%h/%h exp=1/00000000/%h", w_out_valid, w_out_pc, w_out_instr, PAT); end
  endtask

  task automatic test_async_reset;
    do_reset(1'b1, 1'b0, 3);
    repeat (5) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL ar_pre got=%b/%h exp=1/00000000", out_valid, out_pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL ar_immediate got=%b/%b exp=0/0", out_valid, mem_req_valid); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      failures++; $display("FAIL ar_outputs got=%h/%h exp=0/0", out_pc, out_instr); end
    step();
    lat = 1; out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
      failures++; $display("FAIL ar_restart got=%b/%h exp=1/00000000", mem_req_valid, mem_req_addr); end
    repeat (2) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== PAT) begin
      failures++; $display("FAIL ar_first_out got=%b/%h/%h exp=1/00000000/%h", out_valid, out_pc, out_instr, PAT); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
